// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, data and memory-side signals around the unified memory port.
// The slave view belongs to the arbiter; the master view drives both stages and models the memory.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic [DATA_WIDTH-1:0] if_rdata;
  logic                  if_valid;
  logic                  if_stall;
  logic                  flush;
  logic                  d_req;
  logic                  d_we;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic [DATA_WIDTH-1:0] d_rdata;
  logic                  d_valid;
  logic                  d_stall;
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ack;

  modport slave (
    input  if_req, if_addr, flush, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    output if_rdata, if_valid, if_stall, d_rdata, d_valid, d_stall,
           mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, flush, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    input  if_rdata, if_valid, if_stall, d_rdata, d_valid, d_stall,
           mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and data access.
// Data wins ties; a bounded data streak guarantees fetch forward progress.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_DATA_STREAK = 4
) (
  input logic clk,
  input logic reset,
  mem_port_arbiter_if.slave bus
);
  localparam int SW = $clog2(MAX_DATA_STREAK + 1);

  typedef enum logic [1:0] {IDLE, IF_BUSY, D_BUSY} state_t;

  state_t                r_state, w_next;
  logic [SW-1:0]         r_streak;
  logic                  r_drop;
  logic                  r_mem_req, r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata, r_if_rdata, r_d_rdata;
  logic                  r_if_valid, r_d_valid;
  logic                  w_if_elig, w_d_elig, w_grant_if, w_grant_d;

  // A requester whose completion pulse is high this cycle is about to drop its request.
  assign w_if_elig = bus.if_req & ~r_if_valid;
  assign w_d_elig  = bus.d_req  & ~r_d_valid;

  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_grant_if = 1'b0;
    w_grant_d  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_d_elig && (!w_if_elig || r_streak < SW'(MAX_DATA_STREAK))) begin
          w_grant_d = 1'b1;
          w_next    = D_BUSY;
        end else if (w_if_elig) begin
          w_grant_if = 1'b1;
          w_next     = IF_BUSY;
        end
      end
      IF_BUSY, D_BUSY: if (bus.mem_ack) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
      r_if_valid  <= 1'b0;
      r_d_valid   <= 1'b0;
      r_streak    <= '0;
      r_drop      <= 1'b0;
    end else begin
      r_if_valid <= 1'b0;
      r_d_valid  <= 1'b0;
      if (w_grant_d) begin
        r_mem_req   <= 1'b1;
        r_mem_we    <= bus.d_we;
        r_mem_addr  <= bus.d_addr;
        r_mem_wdata <= bus.d_wdata;
        if (!bus.if_req)                           r_streak <= '0;
        else if (r_streak != SW'(MAX_DATA_STREAK)) r_streak <= r_streak + SW'(1);
      end
      if (w_grant_if) begin
        r_mem_req  <= 1'b1;
        r_mem_we   <= 1'b0;
        r_mem_addr <= bus.if_addr;
        r_streak   <= '0;
      end
      if (r_state == IF_BUSY) begin
        if (bus.mem_ack) begin
          r_if_rdata <= bus.mem_rdata;
          r_if_valid <= ~(r_drop | bus.flush);
          r_drop     <= 1'b0;
          r_mem_req  <= 1'b0;
          r_mem_we   <= 1'b0;
        end else if (bus.flush) begin
          r_drop <= 1'b1;
        end
      end
      // Stores leave the last load value visible on d_rdata.
      if (r_state == D_BUSY && bus.mem_ack) begin
        r_d_valid <= 1'b1;
        if (!r_mem_we) r_d_rdata <= bus.mem_rdata;
        r_mem_req <= 1'b0;
        r_mem_we  <= 1'b0;
      end
    end
  end

  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.if_valid  = r_if_valid;
  assign bus.d_rdata   = r_d_rdata;
  assign bus.d_valid   = r_d_valid;
  assign bus.if_stall  = bus.if_req & ~r_if_valid;
  assign bus.d_stall   = bus.d_req & ~r_d_valid;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Random and directed traffic against a transaction-level model of the fetch/data arbiter.
// The bench also plays the memory, with random latency and occasional stray acks while idle.
module tb_mem_port_arbiter;
  localparam int AW = 32, DW = 32, MAXS = 4;

  logic gclk = 1'b0;
  logic reset;
  always #5 gclk = ~gclk;

  mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_DATA_STREAK(MAXS)) dut (
    .clk(gclk), .reset(reset), .bus(bus.slave)
  );

  int n_chk = 0, n_pass = 0;

  task automatic chk(string tag, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  // bench-side memory contents
  logic [31:0] mem_arr [logic [31:0]];
  function automatic logic [31:0] rd_mem(logic [31:0] a);
    return mem_arr.exists(a) ? mem_arr[a] : ((a * 32'h9E3779B9) ^ 32'h0F1E2D3C);
  endfunction

  // reference model: who owns the port, pending drop, and grant history
  int          owner = 0;            // 0 free, 1 fetch, 2 data
  bit          m_drop = 0;
  int          lat_left = 0, lat_fix = -1;
  bit          spur_en = 0, auto_en = 0;
  logic        e_mem_req = 0, e_mem_we = 0, e_if_valid = 0, e_d_valid = 0;
  logic [31:0] e_mem_addr = 0, e_mem_wdata = 0, e_if_rdata = 0, e_d_rdata = 0;
  bit          hist_d[$], hist_f[$];
  logic [31:0] obs_q[$];
  logic        obs_prev = 0;

  // consecutive data grants made while fetch was requesting, since the last reset of that run
  function automatic int streak();
    int n = 0;
    for (int i = hist_d.size() - 1; i >= 0 && n < MAXS; i--) begin
      if (!hist_d[i] || !hist_f[i]) break;
      n++;
    end
    return n;
  endfunction

  function automatic int new_lat();
    return (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 3));
  endfunction

  task automatic model_edge(logic rst, logic ifreq, logic [31:0] ifaddr, logic flsh, logic dreq,
                            logic dwe, logic [31:0] daddr, logic [31:0] dwdata, logic ack,
                            logic [31:0] rdata);
    logic pv_if, pv_d, fe, de;
    pv_if = e_if_valid;
    pv_d  = e_d_valid;
    if (!rst) begin
      owner = 0; m_drop = 0;
      e_mem_req = 0; e_mem_we = 0; e_if_valid = 0; e_d_valid = 0;
      e_mem_addr = 0; e_mem_wdata = 0; e_if_rdata = 0; e_d_rdata = 0;
      hist_d.delete(); hist_f.delete();
    end else begin
      e_if_valid = 0;
      e_d_valid  = 0;
      if (owner == 0) begin
        fe = ifreq && !pv_if;
        de = dreq && !pv_d;
        if (de && (!fe || streak() < MAXS)) begin
          owner = 2; e_mem_req = 1; e_mem_we = dwe; e_mem_addr = daddr; e_mem_wdata = dwdata;
          hist_d.push_back(1); hist_f.push_back(ifreq); lat_left = new_lat();
        end else if (fe) begin
          owner = 1; e_mem_req = 1; e_mem_we = 0; e_mem_addr = ifaddr;
          hist_d.push_back(0); hist_f.push_back(1); lat_left = new_lat();
        end
      end else if (owner == 1) begin
        if (ack) begin
          e_if_rdata = rdata; e_if_valid = !(m_drop || flsh); m_drop = 0;
          owner = 0; e_mem_req = 0; e_mem_we = 0;
        end else if (flsh) m_drop = 1;
      end else if (ack) begin
        e_d_valid = 1;
        if (!e_mem_we) e_d_rdata = rdata;
        else mem_arr[e_mem_addr] = e_mem_wdata;
        owner = 0; e_mem_req = 0; e_mem_we = 0;
      end
    end
  endtask

  task automatic new_d();
    bus.d_we    = 1'($urandom_range(0, 1));
    bus.d_addr  = 32'h1000 | (32'($urandom_range(0, 7)) << 2);
    bus.d_wdata = $urandom;
  endtask

  task automatic agents();
    if (bus.if_req) begin
      if (e_if_valid) begin
        if ($urandom_range(0, 2) == 0) bus.if_req = 0;
        else bus.if_addr = $urandom & 32'h0FFC;
      end
    end else if ($urandom_range(0, 2) == 0) begin
      bus.if_req = 1; bus.if_addr = $urandom & 32'h0FFC;
    end
    bus.flush = ($urandom_range(0, 7) == 0);
    if (bus.flush && owner == 1) bus.if_addr = $urandom & 32'h0FFC;
    if (bus.d_req) begin
      if (e_d_valid) begin
        if ($urandom_range(0, 1) == 0) bus.d_req = 0;
        else new_d();
      end
    end else if ($urandom_range(0, 2) == 0) begin
      bus.d_req = 1; new_d();
    end
  endtask

  task automatic step();
    logic s_rst, s_ifreq, s_flush, s_dreq, s_dwe, s_ack;
    logic [31:0] s_ifaddr, s_daddr, s_dwdata, s_rdata;
    s_rst = reset; s_ifreq = bus.if_req; s_flush = bus.flush; s_dreq = bus.d_req;
    s_dwe = bus.d_we; s_ack = bus.mem_ack; s_ifaddr = bus.if_addr; s_daddr = bus.d_addr;
    s_dwdata = bus.d_wdata; s_rdata = bus.mem_rdata;
    @(posedge gclk);
    model_edge(s_rst, s_ifreq, s_ifaddr, s_flush, s_dreq, s_dwe, s_daddr, s_dwdata, s_ack, s_rdata);
    #1;
    chk("mem_req",   bus.mem_req,   e_mem_req);
    chk("mem_we",    bus.mem_we,    e_mem_we);
    chk("mem_addr",  bus.mem_addr,  e_mem_addr);
    chk("mem_wdata", bus.mem_wdata, e_mem_wdata);
    chk("if_valid",  bus.if_valid,  e_if_valid);
    chk("if_rdata",  bus.if_rdata,  e_if_rdata);
    chk("d_valid",   bus.d_valid,   e_d_valid);
    chk("d_rdata",   bus.d_rdata,   e_d_rdata);
    chk("if_stall",  bus.if_stall,  s_ifreq & ~e_if_valid);
    chk("d_stall",   bus.d_stall,   s_dreq & ~e_d_valid);
    if (bus.mem_req && !obs_prev) obs_q.push_back(bus.mem_addr);
    obs_prev = bus.mem_req;
    if (owner != 0) begin
      if (lat_left == 0) begin bus.mem_ack = 1; bus.mem_rdata = rd_mem(e_mem_addr); end
      else begin lat_left--; bus.mem_ack = 0; bus.mem_rdata = $urandom; end
    end else begin
      bus.mem_ack = spur_en && ($urandom_range(0, 7) == 0);
      bus.mem_rdata = $urandom;
    end
    if (auto_en) agents();
  endtask

  task automatic wait_ifv(string tag);
    bit got = 0;
    for (int k = 0; k < 40 && !got; k++) begin step(); got = e_if_valid; end
    if (!got) chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic wait_dv(string tag);
    bit got = 0;
    for (int k = 0; k < 40 && !got; k++) begin step(); got = e_d_valid; end
    if (!got) chk({tag, "_timeout"}, 0, 1);
  endtask

  initial begin
    int nd, first_f;
    reset = 0;
    bus.if_req = 0; bus.if_addr = 0; bus.flush = 0; bus.d_req = 0; bus.d_we = 0;
    bus.d_addr = 0; bus.d_wdata = 0; bus.mem_rdata = 0; bus.mem_ack = 0;
    mem_arr[32'h40]   = 32'h00A00093;
    mem_arr[32'h1000] = 32'hDEADBEEF;
    repeat (2) step();
    chk("rst_mem_req0", bus.mem_req, 0);
    reset = 1;

    // reset in the middle of a fetch, then a clean fetch
    lat_fix = 6; bus.if_req = 1; bus.if_addr = 32'h240;
    repeat (3) step();
    reset = 0;
    repeat (3) step();
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_if_valid", bus.if_valid, 0);
    reset = 1; lat_fix = 0; bus.if_addr = 32'h100;
    step();
    chk("post_rst_req", bus.mem_req, 1);
    chk("post_rst_addr", bus.mem_addr, 32'h100);
    wait_ifv("post_rst"); bus.if_req = 0;
    step();

    // fetch-only with a one-cycle memory
    bus.if_req = 1; bus.if_addr = 32'h40;
    wait_ifv("fetch");
    chk("fetch_rdata", bus.if_rdata, 32'h00A00093);
    bus.if_req = 0;
    step();

    // simultaneous requests: data first, fetch right after d_valid
    bus.if_req = 1; bus.if_addr = 32'h80;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h1000;
    wait_dv("simul");
    chk("simul_drdata", bus.d_rdata, 32'hDEADBEEF);
    chk("simul_no_fetch", bus.if_valid, 0);
    bus.d_req = 0;
    step();
    chk("simul_f_req", bus.mem_req, 1);
    chk("simul_f_addr", bus.mem_addr, 32'h80);
    wait_ifv("simul_f"); bus.if_req = 0;
    step();

    // streak limit: fetch waits behind back-to-back data grants
    lat_fix = 1; obs_q.delete();
    bus.if_req = 1; bus.if_addr = 32'h80;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h1004;
    first_f = -1;
    for (int k = 0; k < 80 && obs_q.size() < 7; k++) begin
      step();
      if (e_d_valid) bus.d_addr = bus.d_addr + 4;
      if (first_f < 0) begin
        foreach (obs_q[i]) if (obs_q[i] == 32'h80 && first_f < 0) first_f = i;
        bus.if_req = (first_f < 0) ? !e_d_valid : 1'b1;
      end else if (e_if_valid) bus.if_req = 0;
    end
    nd = (first_f < 0) ? obs_q.size() : first_f;
    chk("streak_data_grants", nd, MAXS);
    chk("streak_resume", (obs_q.size() > MAXS + 1) && obs_q[MAXS + 1] != 32'h80, 1);
    if (bus.if_req) wait_ifv("streak_f");
    bus.if_req = 0;
    wait_dv("streak_d"); bus.d_req = 0;
    repeat (2) step();

    // flushed fetch is dropped, the redirected one returns
    lat_fix = 3; obs_q.delete();
    bus.if_req = 1; bus.if_addr = 32'h200;
    step(); step();
    bus.flush = 1; bus.if_addr = 32'h300;
    step();
    bus.flush = 0;
    nd = 0;
    for (int k = 0; k < 4; k++) begin step(); nd += int'(bus.if_valid); end
    chk("flush_no_valid", nd, 0);
    wait_ifv("flush_next");
    chk("flush_next_rdata", bus.if_rdata, rd_mem(32'h300));
    chk("flush_next_addr", obs_q.size() > 1 ? obs_q[1] : 32'h0, 32'h300);
    bus.if_req = 0;
    step();

    // store: write data held until ack, d_rdata keeps the last load
    lat_fix = 0; bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h1000;
    wait_dv("pre_load"); bus.d_req = 0; step();
    lat_fix = 2; bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h2000; bus.d_wdata = 32'h12345678;
    step(); step();
    chk("store_we", bus.mem_we, 1);
    chk("store_wdata", bus.mem_wdata, 32'h12345678);
    wait_dv("store");
    chk("store_keep_rdata", bus.d_rdata, 32'hDEADBEEF);
    bus.d_req = 0;
    step();

    // random traffic with stray acks, flushes and varied latency
    lat_fix = -1; spur_en = 1; auto_en = 1;
    repeat (1500) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
